// File: rtl/lpc_capture_pkg.sv
// Shared register map, bit indices and reset/default constants for the LPC cycle capture FIFO.
package lpc_capture_pkg;

  localparam logic [31:0] LPC_DEFAULT_REG_VALUE = 32'hDEF_FAB_AC;

  // Register offsets within the Wishbone window.
  localparam int unsigned REG_ADDR_CTRL     = 32'h00;
  localparam int unsigned REG_ADDR_STATUS   = 32'h04;
  localparam int unsigned REG_ADDR_DATA     = 32'h08;
  localparam int unsigned REG_ADDR_DROP_CNT = 32'h0C;
  localparam int unsigned REG_ADDR_TSTAMP   = 32'h10;

  // CTRL bits.
  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_IRQ_EN     = 1;
  localparam int unsigned CTRL_FLUSH      = 2;
  localparam int unsigned CTRL_THRESH_LSB = 8;
  localparam int unsigned CTRL_THRESH_MSB = 15;

  // STATUS bits.
  localparam int unsigned STATUS_EMPTY = 16;
  localparam int unsigned STATUS_FULL  = 17;
  localparam int unsigned STATUS_OVF   = 18;

  typedef struct packed {
    logic [7:0] thresh;
    logic       flush;
    logic       irq_en;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] pack_ctrl(input ctrl_t c);
    return {16'h0, c.thresh, 5'h0, c.flush, c.irq_en, c.en};
  endfunction

  function automatic logic [31:0] pack_status(input logic [8:0] level, input logic empty,
                                              input logic full, input logic ovf);
    return {13'h0, ovf, full, empty, 7'h0, level};
  endfunction

endpackage

// File: rtl/lpc_capture_sync_fifo.sv
// Plain synchronous FIFO with flush. The caller decides when a push or pop is legal;
// nothing here drops or counts words.
module lpc_capture_sync_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [Depth];
  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;

  // Storage write; a flush discards the word presented on the same edge.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_i;
    end
  end

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign data_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/lpc_cycle_capture_fifo.sv
// LPC cycle capture FIFO with Wishbone register window, drop counting and level interrupt.
// Optional build macro LPC_CAPTURE_TIMESTAMP_EN stores a 32-bit cycle timestamp with each
// entry and exposes it at the TSTAMP register.
module lpc_cycle_capture_fifo
  import lpc_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned FIFO_DEPTH_LOG2   = 4,
  parameter int unsigned ADDRWIDTH         = 10,
  parameter logic [31:0] DEFAULT_REG_VALUE = LPC_DEFAULT_REG_VALUE,
  parameter int unsigned CAP_EDGE          = 1
) (
  input  logic                  WBs_CLK_i,
  input  logic                  WBs_RST_i,
  input  logic [16:0]           WBs_ADR_i,
  input  logic                  WBs_CYC_i,
  input  logic                  WBs_STB_i,
  input  logic                  WBs_WE_i,
  input  logic [3:0]            WBs_BYTE_STB_i,
  input  logic [31:0]           WBs_DAT_i,
  output logic [31:0]           WBs_DAT_o,
  output logic                  WBs_ACK_o,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  cap_ready_i,
  output logic                  irq_o
);

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  localparam int unsigned EntryWidth = DATA_WIDTH + 32;
`else
  localparam int unsigned EntryWidth = DATA_WIDTH;
`endif
  localparam int unsigned LevelWidth = FIFO_DEPTH_LOG2 + 1;

  logic [ADDRWIDTH-1:0]  adr;
  logic                  access, wr_access, rd_access;
  logic                  sel_ctrl, sel_status, sel_data, sel_drop;
  logic                  ack_q, ovf_q, cap_ready_q, irq_q;
  ctrl_t                 ctrl_q;
  logic [15:0]           drop_cnt_q;
  logic                  push_req, fifo_push, fifo_pop, fifo_flush, drop;
  logic                  fifo_full, fifo_empty;
  logic [LevelWidth-1:0] fifo_level;
  logic [8:0]            level_ext;
  logic [EntryWidth-1:0] fifo_wdata, fifo_rdata;
  logic                  unused_inputs;

  assign unused_inputs = ^{WBs_ADR_i, WBs_DAT_i, WBs_BYTE_STB_i};

  assign adr        = WBs_ADR_i[ADDRWIDTH-1:0];
  assign access     = WBs_CYC_i & WBs_STB_i & ~ack_q;
  assign wr_access  = access & WBs_WE_i;
  assign rd_access  = access & ~WBs_WE_i;
  assign sel_ctrl   = (adr == ADDRWIDTH'(REG_ADDR_CTRL));
  assign sel_status = (adr == ADDRWIDTH'(REG_ADDR_STATUS));
  assign sel_data   = (adr == ADDRWIDTH'(REG_ADDR_DATA));
  assign sel_drop   = (adr == ADDRWIDTH'(REG_ADDR_DROP_CNT));
  assign level_ext  = 9'(fifo_level);

  // Flush acts on the write edge itself; the stored FLUSH bit is only a one-cycle echo.
  assign fifo_flush = wr_access & sel_ctrl & WBs_BYTE_STB_i[0] & WBs_DAT_i[CTRL_FLUSH];
  // Reading DATA while empty is a harmless no-op.
  assign fifo_pop   = rd_access & sel_data & ~fifo_empty;
  assign push_req   = ctrl_q.en & ((CAP_EDGE != 0) ? (cap_ready_i & ~cap_ready_q) : cap_ready_i);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
  assign fifo_push  = push_req & (~fifo_full | fifo_pop) & ~fifo_flush;
  assign drop       = push_req & fifo_full & ~fifo_pop & ~fifo_flush;

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  logic [31:0] tstamp_q;
  logic        sel_tstamp;

  assign sel_tstamp = (adr == ADDRWIDTH'(REG_ADDR_TSTAMP));
  assign fifo_wdata = {tstamp_q, cap_data_i};

  // Free-running cycle counter used to stamp each captured word.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) tstamp_q <= '0;
    else           tstamp_q <= tstamp_q + 32'd1;
  end
`else
  assign fifo_wdata = cap_data_i;
`endif

  lpc_capture_sync_fifo #(
    .WIDTH      (EntryWidth),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (WBs_CLK_i),
    .rst_i   (WBs_RST_i),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Single-cycle acknowledge and capture-ready edge history.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      ack_q       <= 1'b0;
      cap_ready_q <= 1'b0;
    end else begin
      ack_q       <= access;
      cap_ready_q <= cap_ready_i;
    end
  end

  // CTRL register with byte-lane writes; FLUSH clears itself one cycle later.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q.flush <= 1'b0;
      if (wr_access && sel_ctrl) begin
        if (WBs_BYTE_STB_i[0]) begin
          ctrl_q.en     <= WBs_DAT_i[CTRL_EN];
          ctrl_q.irq_en <= WBs_DAT_i[CTRL_IRQ_EN];
          ctrl_q.flush  <= WBs_DAT_i[CTRL_FLUSH];
        end
        if (WBs_BYTE_STB_i[1]) ctrl_q.thresh <= WBs_DAT_i[CTRL_THRESH_MSB:CTRL_THRESH_LSB];
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; a new drop beats a same-cycle OVF clear.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (wr_access && sel_status && WBs_BYTE_STB_i[2] && WBs_DAT_i[STATUS_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (wr_access && sel_drop) begin
        drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Level interrupt on threshold reached or overflow.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ctrl_q.irq_en &
               (((ctrl_q.thresh != 8'd0) && (level_ext >= {1'b0, ctrl_q.thresh})) | ovf_q);
    end
  end

  // Combinational read mux so the value seen during a DATA access is the one popped.
  always_comb begin
    WBs_DAT_o = DEFAULT_REG_VALUE;
    if (sel_ctrl) begin
      WBs_DAT_o = pack_ctrl(ctrl_q);
    end else if (sel_status) begin
      WBs_DAT_o = pack_status(level_ext, fifo_empty, fifo_full, ovf_q);
    end else if (sel_data) begin
      if (!fifo_empty) WBs_DAT_o = 32'(fifo_rdata[DATA_WIDTH-1:0]);
    end else if (sel_drop) begin
      WBs_DAT_o = {16'h0, drop_cnt_q};
    end
`ifdef LPC_CAPTURE_TIMESTAMP_EN
    else if (sel_tstamp) begin
      if (!fifo_empty) WBs_DAT_o = fifo_rdata[EntryWidth-1:DATA_WIDTH];
    end
`endif
  end

  assign WBs_ACK_o = ack_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_lpc_cycle_capture_fifo.sv
// Directed bench for lpc_cycle_capture_fifo (default build, depth 16, edge capture).
module tb_lpc_cycle_capture_fifo;

  localparam logic [31:0] DEF = 32'hDEF_FAB_AC;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] adr;
  logic        cyc, stb, we;
  logic [3:0]  be;
  logic [31:0] wdat, rdat;
  logic        ack;
  logic [31:0] cap_data;
  logic        cap_ready;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lpc_cycle_capture_fifo #(
    .DATA_WIDTH        (32),
    .FIFO_DEPTH_LOG2   (4),
    .ADDRWIDTH         (10),
    .DEFAULT_REG_VALUE (32'hDEF_FAB_AC),
    .CAP_EDGE          (1)
  ) dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_i      (rst),
    .WBs_ADR_i      (adr),
    .WBs_CYC_i      (cyc),
    .WBs_STB_i      (stb),
    .WBs_WE_i       (we),
    .WBs_BYTE_STB_i (be),
    .WBs_DAT_i      (wdat),
    .WBs_DAT_o      (rdat),
    .WBs_ACK_o      (ack),
    .cap_data_i     (cap_data),
    .cap_ready_i    (cap_ready),
    .irq_o          (irq)
  );

  typedef struct {
    bit          is_read;
    logic [16:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic wb_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    adr = a; wdat = d; be = b; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ack_wr", {31'h0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [16:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    adr = a; we = 1'b0; be = 4'hF; cyc = 1'b1; stb = 1'b1;
    #2 d = rdat;
    @(posedge clk);
    @(negedge clk);
    check({name, "_ack"}, {31'h0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0;
    check(name, d, exp);
  endtask

  task automatic push_word(input logic [31:0] d);
    @(negedge clk);
    cap_data = d; cap_ready = 1'b1;
    @(negedge clk);
    cap_ready = 1'b0;
  endtask

  // DATA read and capture edge land on the same clock edge.
  task automatic push_pop(input string name, input logic [31:0] d, input logic [31:0] exp_rd);
    @(negedge clk);
    cap_data = d; cap_ready = 1'b1;
    adr = 17'h08; we = 1'b0; be = 4'hF; cyc = 1'b1; stb = 1'b1;
    #2 check(name, rdat, exp_rd);
    @(posedge clk);
    @(negedge clk);
    cap_ready = 1'b0; cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].is_read) read_check($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
      else                 wb_write(vecs[i].adr, vecs[i].data, vecs[i].be);
    end
  endtask

  initial begin
    //          rd    adr      wdata          be     expected
    vecs[0]  = '{1'b1, 17'h00, 32'h0,         4'h0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 17'h04, 32'h0,         4'h0, 32'h0001_0000};
    vecs[2]  = '{1'b1, 17'h08, 32'h0,         4'h0, DEF};
    vecs[3]  = '{1'b1, 17'h0C, 32'h0,         4'h0, 32'h0000_0000};
    vecs[4]  = '{1'b1, 17'h10, 32'h0,         4'h0, DEF};
    vecs[5]  = '{1'b1, 17'h20, 32'h0,         4'h0, DEF};
    vecs[6]  = '{1'b0, 17'h20, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[7]  = '{1'b1, 17'h00, 32'h0,         4'h0, 32'h0000_0000};
    vecs[8]  = '{1'b0, 17'h00, 32'h0000_FF07, 4'h1, 32'h0};
    vecs[9]  = '{1'b1, 17'h00, 32'h0,         4'h0, 32'h0000_0003};
    vecs[10] = '{1'b0, 17'h00, 32'h0000_0500, 4'h2, 32'h0};
    vecs[11] = '{1'b1, 17'h00, 32'h0,         4'h0, 32'h0000_0503};
    vecs[12] = '{1'b0, 17'h00, 32'h0000_0401, 4'hF, 32'h0};
    vecs[13] = '{1'b1, 17'h00, 32'h0,         4'h0, 32'h0000_0401};
    vecs[14] = '{1'b1, 17'h04, 32'h0,         4'h0, 32'h0000_0001};
    vecs[15] = '{1'b1, 17'h08, 32'h0,         4'h0, 32'h1234_0001};
    vecs[16] = '{1'b1, 17'h04, 32'h0,         4'h0, 32'h0001_0000};

    rst = 1'b1; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; be = '0; wdat = '0;
    cap_data = '0; cap_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_ack", {31'h0, ack}, 32'h0);

    // Register window after reset, unmapped write, byte lanes, then EN=1 THRESH=4.
    run_vecs(0, 13);

    // Level-held ready produces a single edge-triggered capture.
    @(negedge clk);
    cap_data = 32'h1234_0001; cap_ready = 1'b1;
    repeat (10) @(negedge clk);
    cap_ready = 1'b0;
    run_vecs(14, 16);

    // Threshold interrupt.
    wb_write(17'h00, 32'h0000_0403, 4'hF);
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_rise", {31'h0, irq}, 32'h1);
    read_check("data_a0", 17'h08, 32'hA0);
    check("irq_hold", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check("irq_fall", {31'h0, irq}, 32'h0);
    for (int i = 1; i < 4; i++) read_check($sformatf("data_a%0d", i), 17'h08, 32'hA0 + 32'(i));
    check("irq_low", {31'h0, irq}, 32'h0);

    // Overflow: 18 pushes into depth 16.
    wb_write(17'h00, 32'h0000_0001, 4'hF);
    for (int i = 0; i < 18; i++) push_word(32'h100 + 32'(i));
    read_check("status_ovf", 17'h04, 32'h0006_0010);
    read_check("drop_2", 17'h0C, 32'h0000_0002);
    wb_write(17'h04, 32'h0004_0000, 4'hF);
    read_check("status_ovf_clr", 17'h04, 32'h0002_0010);

    // Full FIFO: pop and push on the same edge.
    push_pop("full_pp_rd", 32'h200, 32'h100);
    read_check("full_pp_status", 17'h04, 32'h0002_0010);
    read_check("full_pp_drop", 17'h0C, 32'h0000_0002);
    for (int i = 1; i < 16; i++) read_check($sformatf("drain%0d", i), 17'h08, 32'h100 + 32'(i));
    read_check("drain_last", 17'h08, 32'h200);
    read_check("drained_status", 17'h04, 32'h0001_0000);

    // Empty FIFO: pop is a no-op, push succeeds.
    push_pop("empty_pp_rd", 32'h300, DEF);
    read_check("empty_pp_status", 17'h04, 32'h0000_0001);
    read_check("empty_pp_data", 17'h08, 32'h300);

    // Flush coincident with a push.
    push_word(32'h400);
    push_word(32'h401);
    read_check("pre_flush", 17'h04, 32'h0000_0002);
    @(negedge clk);
    cap_data = 32'h402; cap_ready = 1'b1;
    adr = 17'h00; wdat = 32'h0000_0005; be = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cap_ready = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    read_check("flush_ctrl", 17'h00, 32'h0000_0001);
    read_check("flush_status", 17'h04, 32'h0001_0000);
    read_check("flush_drop", 17'h0C, 32'h0000_0002);

    // Any write clears DROP_CNT; EN=0 blocks captures.
    wb_write(17'h0C, 32'h0, 4'h0);
    read_check("drop_clr", 17'h0C, 32'h0000_0000);
    wb_write(17'h00, 32'h0, 4'hF);
    push_word(32'h500);
    read_check("en_off_status", 17'h04, 32'h0001_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
